pulse_shape_accum: RTL and testbench

Parametrised pulse-shape accumulator for the pulse generation model. For each of `cps` requested pulses it reads a `SHAPE_LEN`-word window from an external single-port BRAM, adds a stored pulse shape (one of `N_SHAPES` selectable tables, e.g. neutron/gamma), and writes the window back. It uses saturating unsigned fixed-point addition, an optional LFSR-randomised window base, a runtime-loadable shape table, and completion and saturation status.

---
 rtl/pulse_shape_accum.sv | 250 +++++++++++++++++++++++++
 tb/tb_pulse_shape_accum.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_shape_accum.sv
// Pulse-shape accumulator: adds a stored shape into a BRAM window per pulse.
// Ports: cps/shape_sel/rand_en control, shape_wr_* table load,
//        bram_* single-port BRAM master, busy/done/pulse_count/sat_flag status.
module pulse_shape_accum #(
    parameter int DATA_W    = 32,
    parameter int SHAPE_LEN = 13,
    parameter int N_SHAPES  = 2,
    parameter int MEM_AW    = 12,
    parameter int LFSR_W    = 11,
    parameter int LFSR_TAP  = 8,
    parameter int LFSR_SEED = 'h555,
    localparam int SEL_W    = (N_SHAPES > 1) ? $clog2(N_SHAPES) : 1,
    localparam int IDX_W    = $clog2(SHAPE_LEN)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       cps,
    input  logic [SEL_W-1:0]  shape_sel,
    input  logic              rand_en,
    input  logic              shape_wr_en,
    input  logic [SEL_W-1:0]  shape_wr_sel,
    input  logic [IDX_W-1:0]  shape_wr_idx,
    input  logic [DATA_W-1:0] shape_wr_data,
    output logic [31:0]       bram_addr,
    output logic [DATA_W-1:0] bram_data_in,
    output logic              bram_we,
    output logic              bram_ena,
    input  logic [DATA_W-1:0] bram_data_out,
    output logic              busy,
    output logic              done,
    output logic [31:0]       pulse_count,
    output logic              sat_flag
);

    localparam int CNT_W  = $clog2(SHAPE_LEN + 1);
    localparam int BASE_W = (LFSR_W < MEM_AW) ? LFSR_W : MEM_AW;

    localparam logic [CNT_W-1:0]  LAST_RD = CNT_W'(SHAPE_LEN);
    localparam logic [CNT_W-1:0]  LAST_WR = CNT_W'(SHAPE_LEN - 1);
    localparam logic [CNT_W-1:0]  ONE_K   = CNT_W'(1);
    localparam logic [MEM_AW-1:0] ONE_A   = MEM_AW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_READ,
        S_WRITE,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        prev_cps_q, prev_cps_d;
    logic [31:0]        count_q, count_d;
    logic               sat_q, sat_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic [LFSR_W-1:0]  lfsr_q, lfsr_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [MEM_AW-1:0]  base_q, base_d;
    logic [CNT_W-1:0]   k_q, k_d;
    logic [MEM_AW-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic               we_q, we_d;
    logic               ena_q, ena_d;
    logic [DATA_W-1:0]  win_q [SHAPE_LEN];
    logic [DATA_W-1:0]  win_d [SHAPE_LEN];
    logic [DATA_W-1:0]  tbl_q [N_SHAPES][SHAPE_LEN];
    logic [DATA_W-1:0]  tbl_d [N_SHAPES][SHAPE_LEN];

    logic               restart;
    logic [DATA_W:0]    sum;

    // Left shift, feedback enters at bit 0; the all-zero lockup state
    // is escaped by forcing 1.
    function automatic logic [LFSR_W-1:0] lfsr_step(
        input logic [LFSR_W-1:0] v
    );
        if (v == '0) begin
            return LFSR_W'(1);
        end
        return {v[LFSR_W-2:0], v[LFSR_W-1] ^ v[LFSR_TAP]};
    endfunction

    // Top bit flags overflow; the low DATA_W bits are already clamped.
    function automatic logic [DATA_W:0] sat_add(
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        logic [DATA_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s[DATA_W]) begin
            s = {1'b1, {DATA_W{1'b1}}};
        end
        return s;
    endfunction

    always_comb begin
        state_d    = state_q;
        prev_cps_d = prev_cps_q;
        count_d    = count_q;
        sat_d      = sat_q;
        lfsr_d     = lfsr_q;
        sel_d      = sel_q;
        base_d     = base_q;
        k_d        = k_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = 1'b0;
        ena_d      = 1'b0;
        win_d      = win_q;
        tbl_d      = tbl_q;
        sum        = '0;
        restart    = (cps != prev_cps_q);

        if (cps == '0) begin
            lfsr_d = lfsr_step(lfsr_q);
        end

        // A new request abandons any pulse in flight; it also takes
        // priority over the DONE bookkeeping of the same cycle.
        if (restart) begin
            prev_cps_d = cps;
            count_d    = '0;
            sat_d      = 1'b0;
            state_d    = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (cps != '0 && count_q < cps) begin
                        state_d = S_PREP;
                    end
                end
                S_PREP: begin
                    sel_d   = shape_sel;
                    base_d  = rand_en ? MEM_AW'(lfsr_q[BASE_W-1:0]) : '0;
                    k_d     = '0;
                    ena_d   = 1'b1;
                    addr_d  = base_d;
                    state_d = S_READ;
                end
                S_READ: begin
                    // Read data trails the address by one cycle.
                    if (k_q != '0) begin
                        win_d[IDX_W'(k_q - ONE_K)] = bram_data_out;
                    end
                    if (k_q == LAST_RD) begin
                        state_d = S_WRITE;
                        k_d     = '0;
                        ena_d   = 1'b1;
                        we_d    = 1'b1;
                        addr_d  = base_q;
                        sum     = sat_add(win_d[0], tbl_q[sel_q][0]);
                        wdata_d = sum[DATA_W-1:0];
                        if (sum[DATA_W]) begin
                            sat_d = 1'b1;
                        end
                    end else begin
                        k_d = k_q + ONE_K;
                        if (k_q < LAST_WR) begin
                            ena_d  = 1'b1;
                            addr_d = base_q + MEM_AW'(k_q) + ONE_A;
                        end
                    end
                end
                S_WRITE: begin
                    if (k_q == LAST_WR) begin
                        state_d = S_DONE;
                    end else begin
                        k_d     = k_q + ONE_K;
                        ena_d   = 1'b1;
                        we_d    = 1'b1;
                        addr_d  = base_q + MEM_AW'(k_d);
                        sum     = sat_add(win_q[IDX_W'(k_d)],
                                          tbl_q[sel_q][IDX_W'(k_d)]);
                        wdata_d = sum[DATA_W-1:0];
                        if (sum[DATA_W]) begin
                            sat_d = 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    count_d = count_q + 32'd1;
                    lfsr_d  = lfsr_step(lfsr_q);
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        // Table loads only while no pulse can be reading the table.
        if (shape_wr_en && !busy_q &&
            32'(shape_wr_idx) < SHAPE_LEN &&
            32'(shape_wr_sel) < N_SHAPES) begin
            tbl_d[shape_wr_sel][shape_wr_idx] = shape_wr_data;
        end

        done_d = (cps != '0) && (count_d == cps);
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            prev_cps_q <= '0;
            count_q    <= '0;
            sat_q      <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            lfsr_q     <= LFSR_W'(LFSR_SEED);
            sel_q      <= '0;
            base_q     <= '0;
            k_q        <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            ena_q      <= 1'b0;
            win_q      <= '{default: '0};
            tbl_q      <= '{default: '{default: '0}};
        end else begin
            state_q    <= state_d;
            prev_cps_q <= prev_cps_d;
            count_q    <= count_d;
            sat_q      <= sat_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            lfsr_q     <= lfsr_d;
            sel_q      <= sel_d;
            base_q     <= base_d;
            k_q        <= k_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            ena_q      <= ena_d;
            win_q      <= win_d;
            tbl_q      <= tbl_d;
        end
    end

    assign bram_addr    = 32'({addr_q, 2'b00});
    assign bram_data_in = wdata_q;
    assign bram_we      = we_q;
    assign bram_ena     = ena_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign pulse_count  = count_q;
    assign sat_flag     = sat_q;

endmodule

// File: tb/tb_pulse_shape_accum.sv
// Bench for pulse_shape_accum: BRAM model, write scoreboard, directed tests.
// Ports: drives all DUT inputs, models the BRAM behind bram_* signals.
module tb_pulse_shape_accum;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] cps;
    logic        shape_sel;
    logic        rand_en;
    logic        shape_wr_en;
    logic        shape_wr_sel;
    logic [3:0]  shape_wr_idx;
    logic [31:0] shape_wr_data;
    logic [31:0] bram_addr;
    logic [31:0] bram_data_in;
    logic        bram_we;
    logic        bram_ena;
    logic [31:0] rd_q;
    logic        busy;
    logic        done;
    logic [31:0] pulse_count;
    logic        sat_flag;

    logic [31:0] mem [0:4095];
    logic [31:0] shadow [0:4095];
    logic [31:0] tm [0:1][0:12];
    logic        pl_clr;
    logic        pl_en;
    logic [11:0] pl_addr;
    logic [31:0] pl_data;
    logic [10:0] lfsr_m;

    wr_t exp_q[$];
    int  tests = 0;
    int  fails = 0;
    int  wr_seen = 0;

    pulse_shape_accum dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cps          (cps),
        .shape_sel    (shape_sel),
        .rand_en      (rand_en),
        .shape_wr_en  (shape_wr_en),
        .shape_wr_sel (shape_wr_sel),
        .shape_wr_idx (shape_wr_idx),
        .shape_wr_data(shape_wr_data),
        .bram_addr    (bram_addr),
        .bram_data_in (bram_data_in),
        .bram_we      (bram_we),
        .bram_ena     (bram_ena),
        .bram_data_out(rd_q),
        .busy         (busy),
        .done         (done),
        .pulse_count  (pulse_count),
        .sat_flag     (sat_flag)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pl_clr) begin
            for (int i = 0; i < 4096; i++) mem[i] <= '0;
        end else if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end else if (bram_ena) begin
            if (bram_we) mem[bram_addr[13:2]] <= bram_data_in;
            else rd_q <= mem[bram_addr[13:2]];
        end
    end

    function automatic logic [10:0] lstep(input logic [10:0] v);
        if (v == '0) return 11'd1;
        return {v[9:0], v[10] ^ v[8]};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr_m <= 11'h555;
        else if (cps == '0) lfsr_m <= lstep(lfsr_m);
    end

    always @(negedge clk) begin
        if (rst_n && bram_ena && bram_we) begin
            wr_seen++;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_write: addr 0x%08h data 0x%08h, none expected",
                         bram_addr, bram_data_in);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (bram_addr !== e.addr || bram_data_in !== e.data) begin
                    fails++;
                    $display("FAIL bram_write: got addr 0x%08h data 0x%08h, expected addr 0x%08h data 0x%08h",
                             bram_addr, bram_data_in, e.addr, e.data);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 4096; i++) shadow[i] = '0;
        pl_clr = 1'b1;
        tick();
        pl_clr = 1'b0;
    endtask

    task automatic poke(input int a, input logic [31:0] d);
        shadow[a] = d;
        pl_addr = 12'(a);
        pl_data = d;
        pl_en = 1'b1;
        tick();
        pl_en = 1'b0;
    endtask

    task automatic tbl_wr(input int s, input int idx, input logic [31:0] d);
        tm[s][idx] = d;
        shape_wr_sel = 1'(s);
        shape_wr_idx = 4'(idx);
        shape_wr_data = d;
        shape_wr_en = 1'b1;
        tick();
        shape_wr_en = 1'b0;
    endtask

    task automatic push_pulse(input int base, input int s, input int n);
        for (int j = 0; j < n; j++) begin
            int a;
            logic [32:0] sm;
            wr_t e;
            a = (base + j) % 4096;
            sm = {1'b0, shadow[a]} + {1'b0, tm[s][j]};
            shadow[a] = sm[32] ? 32'hFFFF_FFFF : sm[31:0];
            e.addr = 32'(a) << 2;
            e.data = shadow[a];
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_done(input string nm, input int bound,
                             output int edges, output int ena_at);
        edges = 0;
        ena_at = -1;
        @(negedge clk);
        while (edges < 2 || (!done && edges < bound)) begin
            @(negedge clk);
            edges++;
            if (ena_at < 0 && bram_ena) ena_at = edges;
        end
        chk({nm, "_done_reached"}, 32'(done), 32'd1);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_addr"}, bram_addr, 32'd0);
        chk({nm, "_wdata"}, bram_data_in, 32'd0);
        chk({nm, "_we"}, 32'(bram_we), 32'd0);
        chk({nm, "_ena"}, 32'(bram_ena), 32'd0);
        chk({nm, "_busy"}, 32'(busy), 32'd0);
        chk({nm, "_done"}, 32'(done), 32'd0);
        chk({nm, "_count"}, pulse_count, 32'd0);
        chk({nm, "_sat"}, 32'(sat_flag), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int edges;
        int ena_at;
        int wr0;
        int bad;
        int b0;
        int b1;
        logic [10:0] l0;

        cps = '0;
        shape_sel = 1'b0;
        rand_en = 1'b0;
        shape_wr_en = 1'b0;
        shape_wr_sel = 1'b0;
        shape_wr_idx = '0;
        shape_wr_data = '0;
        pl_clr = 1'b0;
        pl_en = 1'b0;
        pl_addr = '0;
        pl_data = '0;
        for (int s = 0; s < 2; s++)
            for (int j = 0; j < 13; j++) tm[s][j] = '0;

        clear_mem();
        tick();
        chk_zero("reset");
        rst_n = 1'b1;
        tick();

        // Single pulse, table0 = 1..13
        for (int j = 0; j < 13; j++) tbl_wr(0, j, 32'(j + 1));
        clear_mem();
        push_pulse(0, 0, 13);
        cps = 32'd1;
        wait_done("single", 60, edges, ena_at);
        chk("single_ena_latency", 32'(ena_at), 32'd3);
        chk("single_done_latency", 32'(edges), 32'd31);
        chk("single_count", pulse_count, 32'd1);
        chk("single_word0", mem[0], 32'd1);
        chk("single_word12", mem[12], 32'd13);
        repeat (5) tick();
        chk("single_done_hold", 32'(done), 32'd1);
        chk("single_busy_idle", 32'(busy), 32'd0);

        // Accumulation over 3 pulses, with a table write attempted mid-run
        clear_mem();
        push_pulse(0, 0, 13);
        push_pulse(0, 0, 13);
        push_pulse(0, 0, 13);
        cps = 32'd3;
        repeat (10) tick();
        chk("guard_busy", 32'(busy), 32'd1);
        shape_wr_sel = 1'b0;
        shape_wr_idx = 4'd0;
        shape_wr_data = 32'h7777;
        shape_wr_en = 1'b1;
        tick();
        shape_wr_en = 1'b0;
        wait_done("accum", 150, edges, ena_at);
        chk("accum_count", pulse_count, 32'd3);
        for (int j = 0; j < 13; j++)
            chk($sformatf("accum_word%0d", j), mem[j], 32'(3 * (j + 1)));
        chk("accum_queue_empty", 32'(exp_q.size()), 32'd0);

        // Saturation
        clear_mem();
        poke(0, 32'hFFFF_FFF0);
        tbl_wr(0, 0, 32'h20);
        push_pulse(0, 0, 13);
        cps = 32'd1;
        wait_done("sat", 60, edges, ena_at);
        chk("sat_word0", mem[0], 32'hFFFF_FFFF);
        chk("sat_word1", mem[1], 32'd2);
        chk("sat_flag_set", 32'(sat_flag), 32'd1);
        cps = 32'd0;
        @(negedge clk);
        @(negedge clk);
        chk("sat_flag_clear", 32'(sat_flag), 32'd0);
        chk("sat_done_clear", 32'(done), 32'd0);

        // Restart 5 -> 2 during the second pulse's write phase
        tbl_wr(0, 0, 32'd1);
        clear_mem();
        push_pulse(0, 0, 13);
        push_pulse(0, 0, 6);
        push_pulse(0, 0, 13);
        push_pulse(0, 0, 13);
        wr0 = wr_seen;
        cps = 32'd5;
        edges = 0;
        while (wr_seen < wr0 + 18 && edges < 200) begin
            @(posedge clk);
            edges++;
        end
        chk("restart_reach_write", 32'(wr_seen >= wr0 + 18), 32'd1);
        #1;
        cps = 32'd2;
        @(negedge clk);
        @(negedge clk);
        chk("restart_we_drop", 32'(bram_we), 32'd0);
        chk("restart_count_clr", pulse_count, 32'd0);
        wait_done("restart", 150, edges, ena_at);
        chk("restart_count", pulse_count, 32'd2);
        chk("restart_word0", mem[0], 32'd4);
        chk("restart_word12", mem[12], 32'd39);
        chk("restart_queue_empty", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset in the middle of READ
        cps = 32'd1;
        repeat (8) tick();
        chk("rst_pre_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_zero("midreset");
        cps = 32'd0;
        tick();
        rst_n = 1'b1;
        for (int s = 0; s < 2; s++)
            for (int j = 0; j < 13; j++) tm[s][j] = '0;

        // Table 1 with random window base, two pulses
        for (int j = 0; j < 13; j++) tbl_wr(1, j, 32'h100);
        clear_mem();
        poke(100, 32'h1234);
        shape_sel = 1'b1;
        rand_en = 1'b1;
        l0 = lfsr_m;
        b0 = int'(l0);
        b1 = int'(lstep(l0));
        push_pulse(b0, 1, 13);
        push_pulse(b1, 1, 13);
        cps = 32'd2;
        wait_done("rand", 150, edges, ena_at);
        chk("rand_count", pulse_count, 32'd2);
        chk("rand_sat", 32'(sat_flag), 32'd0);
        chk("rand_queue_empty", 32'(exp_q.size()), 32'd0);
        bad = 0;
        for (int i = 0; i < 4096; i++)
            if (mem[i] !== shadow[i]) bad++;
        chk("rand_mem_vs_model", 32'(bad), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
